// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 forward cipher, one round per clock, round key expanded on the fly.
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   plaintext,secret - block and key, sampled on the accept edge (we=1 while not busy)
//   we               - start request
//   abort            - optional (AES_ENC_ABORT_EN): cancel an encryption in flight
//   cipher           - registered ciphertext
//   busy             - rounds in progress
//   valid            - cipher holds a completed result
// Byte order: bits [127:120] are byte 0; the state is column-major.
// Optional feature macro: AES_ENC_ABORT_EN.
module aes128_enc_iter #(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] plaintext,
  input  logic [127:0] secret,
  input  logic         we,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] cipher,
  output logic         busy,
  output logic         valid
);

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BLOCK_W-1:0] data_q, data_n;
  logic [BLOCK_W-1:0] key_q, key_n;
  logic [BLOCK_W-1:0] cipher_n;
  logic               busy_n, valid_n;
  logic [BLOCK_W-1:0] round_key, sr_sb, mixed;
  logic               abort_req;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [CNT_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // One key schedule step: previous round key to the next one.
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

`ifdef AES_ENC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Shared round datapath.
  assign round_key = key_expand(key_q, rcon_of(cnt));
  assign sr_sb     = shift_rows(sub_bytes(data_q));
  assign mixed     = mix_columns(sr_sb) ^ round_key;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      key_q  <= '0;
      cipher <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      key_q  <= key_n;
      cipher <= cipher_n;
      busy   <= busy_n;
      valid  <= valid_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    data_n   = data_q;
    key_n    = key_q;
    cipher_n = cipher;
    busy_n   = busy;
    valid_n  = valid;
    case (state)
      IDLE, DONE: begin
        if (we) begin
          data_n  = plaintext ^ secret;
          key_n   = secret;
          cnt_n   = CNT_W'(1);
          state_n = ROUND;
          busy_n  = 1'b1;
          valid_n = 1'b0;
          if (CLEAR_ON_START) cipher_n = '0;
        end else if (cnt != '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          valid_n = 1'b0;
        end
      end
      ROUND: begin
        if (abort_req || cnt == '0 || cnt > CNT_W'(LAST_ROUND)) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          valid_n = 1'b0;
        end else if (cnt == CNT_W'(LAST_ROUND)) begin
          // Final round omits MixColumns.
          cipher_n = sr_sb ^ round_key;
          key_n    = round_key;
          cnt_n    = '0;
          state_n  = DONE;
          busy_n   = 1'b0;
          valid_n  = 1'b1;
        end else begin
          key_n  = round_key;
          data_n = mixed;
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: known-answer table, hand-written
// corner sequences and random blocks against a byte-array AES reference model.
module tb_aes128_enc_iter;

  logic         clock;
  logic         reset_n;
  logic [127:0] plaintext;
  logic [127:0] secret;
  logic         we;
  logic [127:0] cipher;
  logic         busy;
  logic         valid;
`ifdef AES_ENC_ABORT_EN
  logic         abort;
`endif

  int n_cmp;
  int n_bad;

  aes128_enc_iter #(.CLEAR_ON_START(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .plaintext (plaintext),
    .secret    (secret),
    .we        (we),
`ifdef AES_ENC_ABORT_EN
    .abort     (abort),
`endif
    .cipher    (cipher),
    .busy      (busy),
    .valid     (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vt [3];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s, rot;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s   = inv ^ 8'h63;
    rot = inv;
    for (int i = 0; i < 4; i++) begin
      rot = {rot[6:0], rot[7]};
      s   = s ^ rot;
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_ref(t[23:16]) ^ rc, sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_ref(st[i]);
      for (int i = 0; i < 16; i++) tmp[i] = st[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            st[4*c+r] = gmul(8'h02, tmp[4*c+r]) ^ gmul(8'h03, tmp[4*c+(r+1)%4]) ^
                        tmp[4*c+(r+2)%4] ^ tmp[4*c+(r+3)%4];
      end else begin
        for (int i = 0; i < 16; i++) st[i] = tmp[i];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a start for one cycle; returns 1 ns after the accept edge.
  task automatic start_enc(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clock);
    plaintext = pt;
    secret    = key;
    we        = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  // Count sampled cycles with busy high, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int           cyc;
    logic [127:0] pt, key, exp, held;
    n_cmp     = 0;
    n_bad     = 0;
    we        = 1'b0;
    plaintext = '0;
    secret    = '0;
    reset_n   = 1'b1;
`ifdef AES_ENC_ABORT_EN
    abort     = 1'b0;
`endif

    vt[0] = '{pt: C1_PT, key: C1_KEY, exp: C1_CT};
    vt[1] = '{pt: B_PT,  key: B_KEY,  exp: B_CT};
    vt[2] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a, key: B_KEY,
              exp: 128'h3ad77bb40d7a3660a89ecaf32466ef97};

    // Reset state
    #2 reset_n = 1'b0;
    #10;
    check128("reset_cipher", cipher, '0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_valid", int'(valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(2);
    check_int("idle_busy", int'(busy), 0);

    // Known-answer table, run back-to-back from DONE
    for (int i = 0; i < 3; i++) begin
      start_enc(vt[i].pt, vt[i].key);
      plaintext = ~vt[i].pt;
      secret    = {$urandom, $urandom, $urandom, $urandom};
      check_int($sformatf("kat%0d_busy_e0", i), int'(busy), 1);
      check_int($sformatf("kat%0d_valid_e0", i), int'(valid), 0);
      check128($sformatf("kat%0d_cleared", i), cipher, '0);
      wait_done(cyc);
      check_int($sformatf("kat%0d_busy_cycles", i), cyc, 10);
      check_int($sformatf("kat%0d_valid", i), int'(valid), 1);
      check128($sformatf("kat%0d_cipher", i), cipher, vt[i].exp);
    end

    // DONE holds its result indefinitely
    step(7);
    check_int("done_hold_valid", int'(valid), 1);
    check128("done_hold_cipher", cipher, vt[2].exp);

    // we while busy is ignored
    start_enc(C1_PT, C1_KEY);
    step(3);
    @(negedge clock);
    plaintext = '1;
    secret    = '1;
    we        = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
    check_int("we_busy_still_busy", int'(busy), 1);
    wait_done(cyc);
    check_int("we_busy_cycles", cyc, 6);
    check128("we_busy_cipher", cipher, C1_CT);

    // Reset between clock edges mid-operation
    start_enc(B_PT, B_KEY);
    step(4);
    #2 reset_n = 1'b0;
    #1;
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_valid", int'(valid), 0);
    check128("midrst_cipher", cipher, '0);
    @(negedge clock);
    reset_n = 1'b1;
    start_enc(C1_PT, C1_KEY);
    wait_done(cyc);
    check_int("postrst_cycles", cyc, 10);
    check128("postrst_cipher", cipher, C1_CT);

`ifdef AES_ENC_ABORT_EN
    // Abort in round 3; cipher keeps the value cleared at start
    start_enc(B_PT, B_KEY);
    step(2);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_valid", int'(valid), 0);
    check128("abort_cipher", cipher, '0);
    step(3);
    check_int("abort_stays_idle", int'(busy), 0);
    start_enc(B_PT, B_KEY);
    wait_done(cyc);
    check128("after_abort_cipher", cipher, B_CT);
    // Abort wins over a simultaneous start request
    start_enc(C1_PT, C1_KEY);
    @(negedge clock);
    abort = 1'b1;
    we    = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    we    = 1'b0;
    check_int("abort_prio_busy", int'(busy), 0);
    check_int("abort_prio_valid", int'(valid), 0);
    step(1);
    check_int("abort_prio_idle", int'(busy), 0);
    start_enc(C1_PT, C1_KEY);
    wait_done(cyc);
    check128("after_prio_cipher", cipher, C1_CT);
`endif

    // Random blocks against the reference model; inputs scrambled after accept
    for (int i = 0; i < 8; i++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_encrypt(pt, key);
      start_enc(pt, key);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      secret    = {$urandom, $urandom, $urandom, $urandom};
      wait_done(cyc);
      check_int($sformatf("rand%0d_cycles", i), cyc, 10);
      check128($sformatf("rand%0d_cipher", i), cipher, exp);
      held = cipher;
      if (i == 7) begin
        step(3);
        check128("rand_final_hold", cipher, held);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
